// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits answer combinationally; misses and stores stall while a valid/ready memory transaction runs.
module dcache #(
  parameter int SETS      = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [1:0]           req_width,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                 state_reg;
  logic [SETS-1:0]        valid_reg;
  logic [TW-1:0]          tag_mem [SETS];
  logic [31:0]            data_mem [SETS];

  logic [29:0]            addr_reg;
  logic [31:0]            wdata_reg;
  logic [3:0]             strb_reg;
  logic                   mem_req_reg;
  logic                   mem_we_reg;
  logic [CNT_WIDTH-1:0]   hit_count_reg;
  logic [CNT_WIDTH-1:0]   miss_count_reg;

  logic [1:0]             req_off;
  logic [IW-1:0]          req_index;
  logic [TW-1:0]          req_tag;
  logic                   line_hit;
  logic [3:0]             lane_strb;
  logic [31:0]            lane_data;

  logic [IW-1:0]          reg_index;
  logic [TW-1:0]          reg_tag;
  logic                   write_hit;
  logic [31:0]            old_word;
  logic [31:0]            merged_word;
  logic                   fill_done;
  logic                   write_done;

  assign req_off   = req_addr[1:0];
  assign req_index = req_addr[2+IW-1:2];
  assign req_tag   = req_addr[31:2+IW];
  assign line_hit  = valid_reg[req_index] && (tag_mem[req_index] == req_tag);

  assign reg_index = addr_reg[IW-1:0];
  assign reg_tag   = addr_reg[29:IW];
  assign write_hit = valid_reg[reg_index] && (tag_mem[reg_index] == reg_tag);
  assign old_word  = data_mem[reg_index];

  assign fill_done  = (state_reg == FILL)  && mem_ready;
  assign write_done = (state_reg == WRITE) && mem_ready;

  // Place store data into its byte lanes; a misaligned half ignores off[0].
  always_comb begin
    lane_strb = 4'b1111;
    lane_data = req_wdata;
    case (req_width)
      2'b10: begin
        lane_strb = 4'b0001 << req_off;
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << {req_off[1], 1'b0};
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = strb_reg[gi] ? wdata_reg[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

  // Line storage is not reset; only the valid bits carry reset state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        data_mem[reg_index] <= mem_rdata;
        tag_mem[reg_index]  <= reg_tag;
      end else if (write_done && write_hit) begin
        data_mem[reg_index] <= merged_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (req_we) begin
              state_reg   <= WRITE;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= 1'b1;
              addr_reg    <= req_addr[31:2];
              wdata_reg   <= lane_data;
              strb_reg    <= lane_strb;
            end else if (line_hit) begin
              if (hit_count_reg != '1)
                hit_count_reg <= hit_count_reg + CNT_WIDTH'(1);
            end else begin
              state_reg   <= FILL;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= 1'b0;
              addr_reg    <= req_addr[31:2];
              wdata_reg   <= lane_data;
              strb_reg    <= lane_strb;
              if (miss_count_reg != '1)
                miss_count_reg <= miss_count_reg + CNT_WIDTH'(1);
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            valid_reg[reg_index] <= 1'b1;
            state_reg            <= IDLE;
            mem_req_reg          <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  // A store releases the CPU in its mem_ready cycle; a fill always returns via a hit cycle.
  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE:    stall = req_valid && (req_we || !line_hit);
      FILL:    stall = 1'b1;
      WRITE:   stall = !mem_ready;
      default: stall = 1'b0;
    endcase
  end

  assign rdata      = data_mem[req_index];
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = {addr_reg, 2'b00};
  assign mem_wdata  = wdata_reg;
  assign mem_wstrb  = strb_reg;
  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized accesses checked
// against a transparent-cache model (backing memory word map plus line residency table).
module tb_dcache;
  localparam int SETS = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [1:0]    req_width;
  logic [31:0]   rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  dcache #(.SETS(SETS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_width(req_width),
    .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: backing memory by word address, which word each line holds, counters.
  logic [31:0] mem_model [logic [29:0]];
  bit          m_valid   [SETS];
  logic [29:0] m_word    [SETS];
  int          m_hits;
  int          m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    if (mem_model.exists(w)) return mem_model[w];
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
  endtask

  // One CPU access held until stall drops; memory answers after n wait cycles.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input int n);
    logic [29:0] waddr;
    int          idx;
    bit          exp_hit;
    int          exp_stall;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] nw;
    int          stall_cycles;
    int          waitc;
    bit          done;
    logic [31:0] got_rdata;
    logic        got_memreq;

    waddr   = addr[31:2];
    idx     = int'(waddr % SETS);
    exp_hit = !we && m_valid[idx] && (m_word[idx] == waddr);
    exp_stall = we ? 1 + n : (exp_hit ? 0 : 2 + n);
    case (width)
      2'b10: begin exp_strb = 4'b0001 << addr[1:0]; exp_wd = {4{wdata[7:0]}}; end
      2'b01: begin exp_strb = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wdata[15:0]}}; end
      default: begin exp_strb = 4'b1111; exp_wd = wdata; end
    endcase

    stall_cycles = 0; waitc = 0; done = 1'b0;
    got_rdata = '0; got_memreq = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_width = width;
      mem_ready = mem_req && (waitc == n);
      mem_rdata = mem_ready ? mem_word(waddr) : $urandom;
      #1;
      if (mem_req) begin
        check("mem_addr", mem_addr, {waddr, 2'b00});
        check("mem_we", 32'(mem_we), 32'(we));
        if (we) begin
          check("mem_wdata", mem_wdata, exp_wd);
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
        end
        waitc++;
      end
      if (stall) stall_cycles++;
      else begin
        done       = 1'b1;
        got_rdata  = rdata;
        got_memreq = mem_req;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    check("release_mem_req", 32'(got_memreq), 32'(we));
    if (!we) check("rdata", got_rdata, mem_word(waddr));

    if (we) begin
      nw = mem_word(waddr);
      for (int b = 0; b < 4; b++)
        if (exp_strb[b]) nw[b*8 +: 8] = exp_wd[b*8 +: 8];
      mem_model[waddr] = nw;
    end else if (exp_hit) begin
      m_hits = sat_inc(m_hits);
    end else begin
      m_misses    = sat_inc(m_misses);
      m_hits      = sat_inc(m_hits);
      m_valid[idx] = 1'b1;
      m_word[idx]  = waddr;
    end

    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("miss_count", 32'(miss_count), 32'(m_misses));
    $display("acc we=%0d addr=%h width=%0d wait=%0d stalls=%0d rdata=%h hits=%0d misses=%0d",
             we, addr, width, n, stall_cycles, got_rdata, hit_count, miss_count);
  endtask

  // Reset arrives while a fill is outstanding; the late ready must be ignored.
  task automatic reset_during_fill(input logic [31:0] addr);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_width = 2'b00; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    check("rdf_fill_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    #1;
    check("rdf_mem_req", 32'(mem_req), 32'd0);
    check("rdf_hits", 32'(hit_count), 32'd0);
    check("rdf_misses", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("rdf_late_ready", 32'(mem_req), 32'd0);
    model_reset();
    $display("acc reset_during_fill addr=%h", addr);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_width = 2'b00; mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    apply_reset();

    // Cold miss, repeat hit, byte store merge, store miss without allocate.
    mem_model[30'h40] = 32'hDEADBEEF;
    do_access(1'b0, 32'h100, 32'h0, 2'b00, 2);
    check("tp_cold_rdata_model", mem_word(30'h40), 32'hDEADBEEF);
    check("tp_cold_misses", 32'(miss_count), 32'd1);
    do_access(1'b0, 32'h100, 32'h0, 2'b00, 0);
    check("tp_rep_hits", 32'(hit_count), 32'd2);
    do_access(1'b1, 32'h102, 32'hAB, 2'b10, 1);
    do_access(1'b0, 32'h100, 32'h0, 2'b00, 0);
    check("tp_merge_misses", 32'(miss_count), 32'd1);
    check("tp_merge_model", mem_word(30'h40), 32'hDEABBEEF);
    do_access(1'b1, 32'h200, 32'h0000_5555, 2'b00, 0);
    do_access(1'b0, 32'h200, 32'h0, 2'b00, 1);
    check("tp_noalloc_misses", 32'(miss_count), 32'd2);

    // Aliasing on index 0.
    apply_reset();
    do_access(1'b0, 32'h100, 32'h0, 2'b00, 0);
    do_access(1'b0, 32'h200, 32'h0, 2'b00, 1);
    do_access(1'b0, 32'h100, 32'h0, 2'b00, 0);
    check("tp_alias_misses", 32'(miss_count), 32'd3);

    reset_during_fill(32'h300);
    do_access(1'b0, 32'h300, 32'h0, 2'b00, 0);
    check("tp_rdf_remiss", 32'(miss_count), 32'd1);

    // Randomized traffic over a small address pool so hits, aliases and saturation all occur.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_access(($urandom_range(0, 9) < 3), a, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache.md
# dcache

Parametrised direct-mapped, write-through, no-write-allocate data cache between the CPU's load/store path and the backing data memory. It replaces the CPU's direct single-cycle connection to `datamem` with a stall-based handshake. Read hits complete in the request cycle, so a hitting load still behaves as single-cycle. Misses and all stores stall the CPU while a simple valid/ready transaction runs on the memory side. Saturating hit/miss counters are included for performance measurement.

## Interface

Parameters:
- `SETS`, 64: number of lines, one 32-bit word per line; power of two, at least 2.
- `CNT_WIDTH`, 16: width of each performance counter.

Ports:
- `clk`, input, 1: the block's single clock.
- `rst`, input, 1: synchronous reset, active-high.
- `req_valid`, input, 1: CPU access this cycle.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data, aligned to byte lane 0 (register value).
- `req_width`, input, 2: access width; 00 = word, 01 = half, 10 = byte, 11 = treated as word.
- `rdata`, output, 32: full aligned word containing the addressed data. Extension is done by the CPU load path.
- `stall`, output, 1: CPU must hold the request and its PC.
- `mem_req`, output, 1: memory transaction active.
- `mem_we`, output, 1: 1 = write, 0 = read fill.
- `mem_addr`, output, 32: word-aligned address (`req_addr[31:2]`, `2'b00`).
- `mem_wdata`, output, 32: store data shifted into its byte lanes.
- `mem_wstrb`, output, 4: byte enables.
- `mem_ready`, input, 1: memory completes the transaction this cycle.
- `mem_rdata`, input, 32: fill data, valid while `mem_ready` is high.
- `hit_count`, output, CNT_WIDTH: saturating count of load hits.
- `miss_count`, output, CNT_WIDTH: saturating count of load misses.

## Operation

- Address split:
  - offset = `addr[1:0]`
  - index = `addr[2+IW-1:2]`, where IW = log2(SETS)
  - tag = `addr[31:2+IW]`
- Per line: valid bit, tag, 32-bit data.
- Lane placement:
  - Byte: strobe = `4'b0001 << off`; data = `wdata[7:0]` replicated ×4.
  - Half: strobe = `4'b0011 << {off[1],1'b0}`; data = `wdata[15:0]` replicated ×2. Misaligned `off[0]` is ignored.
  - Word: strobe = `4'b1111`.
- FSM has three states: IDLE, FILL, WRITE.
- IDLE:
  - Load hit (valid and tag match): `rdata` = line data combinationally, `stall` = 0, `hit_count` increments.
  - Load miss: `stall` = 1, go to FILL, `miss_count` increments once.
  - Store (hit or miss): `stall` = 1, go to WRITE.
  - Request fields are registered on the transition into FILL or WRITE. Memory-side outputs are driven from these registered copies.
- FILL:
  - `mem_req` = 1, `mem_we` = 0, `stall` = 1.
  - On `mem_ready`: write `mem_rdata` into the line, set valid, load the tag, go to IDLE.
  - The held request then hits on the next cycle; that hit increments `hit_count`.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `stall` = `!mem_ready`.
  - On `mem_ready`: if the line is valid with a matching tag, merge the strobed bytes into the line. Otherwise the line is unchanged (no allocate). Go to IDLE.
  - The CPU advances past the store in the `mem_ready` cycle.
- `req_valid` = 0 in IDLE: no stall, no memory activity, `rdata` is don't-care.
- Counters saturate at all-ones and never wrap.

## Timing

- Reset values, applied on the first rising edge with `rst` high:
  - state = IDLE, all valid bits = 0, both counters = 0.
  - `mem_req` = 0, `stall` = 0 (with `req_valid` low).
  - Line data and tags are not reset.
- Load-hit latency is 0 cycles (combinational, same cycle).
- Load-miss latency is 2 + N cycles, where N = number of cycles `mem_req` is held before `mem_ready` (N ≥ 0 wait cycles):
  - Cycle 0: miss detected.
  - Cycles 1..1+N: FILL.
  - Next cycle: hit.
- Store occupancy is 1 + (N+1) cycles.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` are stable from `mem_req` rise until the `mem_ready` cycle inclusive.
  - `mem_req` falls the cycle after `mem_ready`.
  - `mem_ready` is ignored while `mem_req` = 0.
- `rst` during FILL or WRITE: state returns to IDLE and `mem_req` = 0 the next cycle. A late `mem_ready` is ignored, and no line is written.
- A load immediately after a store to the same address sees the updated line on a hit, or misses if the store did not allocate.
- Index aliasing: a fill overwrites the line regardless of its previous tag.

## Test plan

- Cold load from 0x100 with `mem_ready` after 2 wait cycles and `mem_rdata` = 0xDEADBEEF:
  - `stall` high for 4 cycles, then `rdata` = 0xDEADBEEF with `stall` low.
  - `miss_count` = 1, `hit_count` = 1.
- Repeat load from 0x100: zero-cycle hit, no `mem_req`, `hit_count` = 2.
- Byte store of 0xAB to 0x102 (line 0x100 cached as 0xDEADBEEF):
  - `mem_wstrb` = 0100, `mem_wdata` = 0xABABABAB.
  - Following load returns 0xDEABBEEF with no miss.
- Store to uncached 0x200: one memory write. Following load from 0x200 misses (no allocate).
- Alias, SETS = 64: load 0x100, then 0x200 (same index, different tag), then 0x100. All three miss, `miss_count` = 3.
- Assert `rst` during FILL, with `mem_ready` arriving the following cycle:
  - `mem_req` = 0 after reset.
  - Next load from the same address misses again.
  - Counters = 0 after reset.
